// File: rtl/cpu_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, opcode constants and
// the instruction-length table used by both fetch and decode.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_VEC_LO,
    ST_VEC_HI,
    ST_VEC_LD,
    ST_OP,
    ST_OPC,
    ST_LO,
    ST_HI,
    ST_VALID
  } fetch_state_e;

  // two-byte opcodes
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDA_ZP  = 8'hA5;
  localparam logic [7:0] OP_LDX_IMM = 8'hA2;
  localparam logic [7:0] OP_LDY_IMM = 8'hA0;
  localparam logic [7:0] OP_STA_ZP  = 8'h85;
  localparam logic [7:0] OP_ADC_IMM = 8'h69;
  localparam logic [7:0] OP_SBC_IMM = 8'hE9;
  localparam logic [7:0] OP_AND_IMM = 8'h29;
  localparam logic [7:0] OP_ORA_IMM = 8'h09;
  localparam logic [7:0] OP_EOR_IMM = 8'h49;
  localparam logic [7:0] OP_CMP_IMM = 8'hC9;
  localparam logic [7:0] OP_BPL     = 8'h10;
  localparam logic [7:0] OP_BMI     = 8'h30;
  localparam logic [7:0] OP_BVC     = 8'h50;
  localparam logic [7:0] OP_BVS     = 8'h70;
  localparam logic [7:0] OP_BCC     = 8'h90;
  localparam logic [7:0] OP_BCS     = 8'hB0;
  localparam logic [7:0] OP_BNE     = 8'hD0;
  localparam logic [7:0] OP_BEQ     = 8'hF0;
  // three-byte opcodes
  localparam logic [7:0] OP_LDA_ABS = 8'hAD;
  localparam logic [7:0] OP_STA_ABS = 8'h8D;
  localparam logic [7:0] OP_JMP     = 8'h4C;
  localparam logic [7:0] OP_JSR     = 8'h20;
  // one-byte
  localparam logic [7:0] OP_NOP     = 8'hEA;

  // Unknown opcodes fall to length 1 and execute as NOP.
  function automatic logic [1:0] instr_len(input logic [7:0] opcode);
    case (opcode)
      OP_LDA_IMM, OP_LDA_ZP, OP_LDX_IMM, OP_LDY_IMM, OP_STA_ZP,
      OP_ADC_IMM, OP_SBC_IMM, OP_AND_IMM, OP_ORA_IMM, OP_EOR_IMM,
      OP_CMP_IMM, OP_BPL, OP_BMI, OP_BVC, OP_BVS, OP_BCC, OP_BCS,
      OP_BNE, OP_BEQ:                              return 2'd2;
      OP_LDA_ABS, OP_STA_ABS, OP_JMP, OP_JSR:      return 2'd3;
      default:                                     return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// 16-bit program counter: load wins over advance, advance adds the
// instruction length modulo 2^16.
module fetch_pc_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_pc,
  input  logic        adv,
  input  logic [1:0]  adv_len,
  output logic [15:0] pc
);

  // PC update: reset, then load, then advance
  always_ff @(posedge clk) begin
    if (rst)       pc <= 16'h0000;
    else if (load) pc <= load_pc;
    else if (adv)  pc <= pc + {14'b0, adv_len};
  end

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch: reads the reset vector, then fetches opcode and operand
// bytes and hands one whole instruction per valid/ready transfer downstream.
module cpu_fetch
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_opcode,
  output logic [15:0] out_operand,
  output logic [1:0]  out_len,
  output logic [15:0] out_pc
);

  fetch_state_e state, state_nxt;
  logic [15:0]  pc;
  logic [7:0]   vec_lo;
  logic [1:0]   op_len;
  logic         redir_ok;
  logic         xfer;
  logic         pc_load;
  logic [15:0]  pc_load_val;

  // Redirects only take effect once the vector has been loaded.
  assign redir_ok    = redirect && (state != ST_VEC_LO) && (state != ST_VEC_HI)
                       && (state != ST_VEC_LD);
  assign xfer        = (state == ST_VALID) && out_ready;
  assign pc_load     = redir_ok || (state == ST_VEC_LD);
  assign pc_load_val = (state == ST_VEC_LD) ? {mem_rdata, vec_lo} : redirect_pc;

  fetch_pc_reg u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_load),
    .load_pc (pc_load_val),
    .adv     (xfer),
    .adv_len (out_len),
    .pc      (pc)
  );

  // Next state and memory read issue; reads are gated off during reset
  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_addr  = 16'h0000;
    op_len    = instr_len(mem_rdata);
    case (state)
      ST_VEC_LO: begin
        mem_rd    = 1'b1;
        mem_addr  = RESET_VECTOR;
        state_nxt = ST_VEC_HI;
      end
      ST_VEC_HI: begin
        mem_rd    = 1'b1;
        mem_addr  = RESET_VECTOR + 16'd1;
        state_nxt = ST_VEC_LD;
      end
      ST_VEC_LD: state_nxt = ST_OP;
      ST_OP: begin
        mem_rd    = 1'b1;
        mem_addr  = pc;
        state_nxt = ST_OPC;
      end
      ST_OPC: begin
        // length is decoded straight off the returning opcode byte
        if (op_len != 2'd1) begin
          mem_rd   = 1'b1;
          mem_addr = pc + 16'd1;
        end
        state_nxt = (op_len == 2'd1) ? ST_VALID : ST_LO;
      end
      ST_LO: begin
        if (out_len == 2'd3) begin
          mem_rd   = 1'b1;
          mem_addr = pc + 16'd2;
        end
        state_nxt = (out_len == 2'd2) ? ST_VALID : ST_HI;
      end
      ST_HI:    state_nxt = ST_VALID;
      ST_VALID: if (out_ready) state_nxt = ST_OP;
      default:  state_nxt = ST_VEC_LO;
    endcase
    if (redir_ok) state_nxt = ST_OP;
    if (rst) begin
      mem_rd   = 1'b0;
      mem_addr = 16'h0000;
    end
  end

  // State, vector byte and registered instruction outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_VEC_LO;
      vec_lo      <= 8'h00;
      out_valid   <= 1'b0;
      out_opcode  <= 8'h00;
      out_operand <= 16'h0000;
      out_len     <= 2'd1;
      out_pc      <= 16'h0000;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == ST_VALID);
      if (state == ST_VEC_HI) vec_lo <= mem_rdata;
      // a redirect discards whatever byte is returning this cycle
      if (!redir_ok) begin
        case (state)
          ST_OPC: begin
            out_opcode  <= mem_rdata;
            out_len     <= op_len;
            out_operand <= 16'h0000;
            out_pc      <= pc;
          end
          ST_LO:   out_operand[7:0]  <= mem_rdata;
          ST_HI:   out_operand[15:8] <= mem_rdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_fetch.sv
// Bench for cpu_fetch: transaction-level model of the instruction stream
// (PC, memory image, length table) plus cycle-count checks on latency.
module tb_cpu_fetch;

  localparam logic [15:0] RV = 16'hFFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata = 8'h00;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_opcode;
  logic [15:0] out_operand;
  logic [1:0]  out_len;
  logic [15:0] out_pc;

  logic [7:0]  mem [0:65535];

  int n_chk = 0;
  int n_fail = 0;

  // model state
  logic [15:0] exp_pc = 16'h0000;
  int          since_rst = 0;
  int          op_cnt = 0;
  bit          op_cnt_ok = 0;
  bit          prev_rst = 0;
  bit          prev_valid = 0;
  bit          redir_prev = 0;
  logic [15:0] redir_prev_pc = 16'h0000;
  bit          hs_seen = 0;
  bit          saw_valid = 0;
  logic [15:0] hs_pc_q[$];
  logic [7:0]  hs_op_q[$];
  logic [15:0] hs_opnd_q[$];

  cpu_fetch #(.RESET_VECTOR(RV)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_operand (out_operand),
    .out_len     (out_len),
    .out_pc      (out_pc)
  );

  always #5 clk = ~clk;

  // synchronous memory: data the cycle after the read strobe
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ref_len(input logic [7:0] op);
    if (op inside {8'hA9, 8'hA5, 8'hA2, 8'hA0, 8'h85, 8'h69, 8'hE9, 8'h29, 8'h09,
                   8'h49, 8'hC9, 8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0,
                   8'hD0, 8'hF0})
      return 2;
    if (op inside {8'hAD, 8'h8D, 8'h4C, 8'h20}) return 3;
    return 1;
  endfunction

  // One clock: drive inputs, check outputs against the model, advance model.
  task automatic tick(input bit r, input bit rdy, input bit rd, input logic [15:0] rpc);
    logic [15:0] a1, a2, opnd;
    int          l;
    bit          hs;
    @(negedge clk);
    rst = r; out_ready = rdy; redirect = rd; redirect_pc = rpc;
    #1;
    l = 1;
    hs = 0;
    if (prev_rst) begin
      chk("rst_valid",   out_valid,   0);
      chk("rst_opcode",  out_opcode,  8'h00);
      chk("rst_operand", out_operand, 16'h0000);
      chk("rst_len",     out_len,     1);
      chk("rst_pc",      out_pc,      16'h0000);
    end
    if (r) begin
      chk("rst_mem_rd",   mem_rd,   0);
      chk("rst_mem_addr", mem_addr, 16'h0000);
    end else if (since_rst == 0) begin
      chk("vec_addr", mem_addr, RV);
      chk("vec_rd",   mem_rd,   1);
    end else if (since_rst == 3) begin
      chk("first_op_addr", mem_addr, exp_pc);
      chk("first_op_rd",   mem_rd,   1);
    end
    if (!r && redir_prev) begin
      chk("redir_addr",  mem_addr,  redir_prev_pc);
      chk("redir_rd",    mem_rd,    1);
      chk("redir_valid", out_valid, 0);
    end
    saw_valid = out_valid;
    if (!prev_rst && out_valid) begin
      a1 = exp_pc + 16'd1;
      a2 = exp_pc + 16'd2;
      l = ref_len(mem[exp_pc]);
      opnd = (l == 3) ? {mem[a2], mem[a1]} : (l == 2) ? {8'h00, mem[a1]} : 16'h0000;
      chk("out_pc",      out_pc,      exp_pc);
      chk("out_opcode",  out_opcode,  mem[exp_pc]);
      chk("out_len",     out_len,     l);
      chk("out_operand", out_operand, opnd);
      chk("valid_no_rd", mem_rd,      0);
      if (!prev_valid && op_cnt_ok) chk("valid_latency", op_cnt, l + 1);
      hs = rdy;
      if (hs) begin
        hs_pc_q.push_back(out_pc);
        hs_op_q.push_back(out_opcode);
        hs_opnd_q.push_back(out_operand);
      end
    end
    prev_valid = out_valid;
    @(posedge clk);
    redir_prev = 0;
    if (r) begin
      since_rst = 0;
      exp_pc = {mem[RV + 16'd1], mem[RV]};
      op_cnt_ok = 0;
      prev_rst = 1;
      prev_valid = 0;
    end else begin
      prev_rst = 0;
      since_rst++;
      op_cnt++;
      if (hs) hs_seen = 1;
      if (rd && since_rst >= 4) begin
        exp_pc = rpc;
        op_cnt = 0;
        op_cnt_ok = 1;
        redir_prev = 1;
        redir_prev_pc = rpc;
      end else if (hs) begin
        exp_pc = exp_pc + 16'(l);
        op_cnt = 0;
      end else if (since_rst == 3) begin
        op_cnt = 0;
        op_cnt_ok = 1;
      end
    end
  endtask

  task automatic run_until_hs(input int budget, input string tag);
    int n;
    hs_seen = 0;
    n = 0;
    while (!hs_seen && n < budget) begin
      tick(0, 1, 0, 16'h0000);
      n++;
    end
    if (!hs_seen) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n;
    saw_valid = 0;
    n = 0;
    while (!saw_valid && n < budget) begin
      tick(0, 0, 0, 16'h0000);
      n++;
    end
    if (!saw_valid) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42; mem[16'h8002] = 8'hAD;
    mem[16'h8003] = 8'h34; mem[16'h8004] = 8'h12; mem[16'h8005] = 8'hEA;
    mem[16'hA000] = 8'hAD; mem[16'hA001] = 8'h34; mem[16'hA002] = 8'h12;
    mem[16'h9000] = 8'hEA;
    mem[16'hFFFE] = 8'h4C; mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22;

    tick(1, 0, 0, 16'h0000);
    tick(1, 0, 0, 16'h0000);

    // mixed stream from the reset vector
    hs_pc_q.delete(); hs_op_q.delete(); hs_opnd_q.delete();
    repeat (3) run_until_hs(30, "mixed");
    chk("mixed_count", hs_pc_q.size(), 3);
    if (hs_pc_q.size() >= 3) begin
      chk("mixed_pc0", hs_pc_q[0], 16'h8000);
      chk("mixed_pc1", hs_pc_q[1], 16'h8002);
      chk("mixed_pc2", hs_pc_q[2], 16'h8005);
      chk("mixed_op0", hs_op_q[0], 8'hA9);
      chk("mixed_op1", hs_op_q[1], 8'hAD);
      chk("mixed_op2", hs_op_q[2], 8'hEA);
      chk("mixed_opnd0", hs_opnd_q[0], 16'h0042);
      chk("mixed_opnd1", hs_opnd_q[1], 16'h1234);
      chk("mixed_opnd2", hs_opnd_q[2], 16'h0000);
    end

    // backpressure: hold in VALID for 5 cycles
    wait_valid(30, "bp");
    repeat (5) tick(0, 0, 0, 16'h0000);
    run_until_hs(30, "bp");

    // redirect while fetching operand lo of AD 34 12
    tick(0, 1, 1, 16'hA000);
    tick(0, 1, 0, 16'h0000);
    tick(0, 1, 0, 16'h0000);
    tick(0, 1, 1, 16'h9000);
    hs_pc_q.delete(); hs_op_q.delete(); hs_opnd_q.delete();
    run_until_hs(30, "redir_lo");
    if (hs_pc_q.size() > 0) chk("redir_lo_pc", hs_pc_q[0], 16'h9000);

    // redirect coincident with a transfer
    wait_valid(30, "redir_hs");
    tick(0, 1, 1, 16'hB000);
    hs_pc_q.delete(); hs_op_q.delete(); hs_opnd_q.delete();
    run_until_hs(30, "redir_hs");
    if (hs_pc_q.size() > 0) chk("redir_hs_pc", hs_pc_q[0], 16'hB000);

    // 3-byte instruction wrapping past FFFF
    tick(0, 0, 1, 16'hFFFE);
    hs_pc_q.delete(); hs_op_q.delete(); hs_opnd_q.delete();
    run_until_hs(30, "wrap");
    run_until_hs(30, "wrap_next");
    chk("wrap_count", hs_pc_q.size(), 2);
    if (hs_pc_q.size() >= 2) begin
      chk("wrap_pc",   hs_pc_q[0],   16'hFFFE);
      chk("wrap_opnd", hs_opnd_q[0], 16'h2211);
      chk("wrap_next", hs_pc_q[1],   16'h0001);
    end

    // reset pulse while fetching operand hi
    tick(0, 0, 1, 16'hA000);
    repeat (3) tick(0, 0, 0, 16'h0000);
    tick(1, 0, 0, 16'h0000);
    hs_pc_q.delete(); hs_op_q.delete(); hs_opnd_q.delete();
    run_until_hs(30, "rst_mid");
    if (hs_pc_q.size() > 0) chk("rst_mid_pc", hs_pc_q[0], 16'h8000);

    // randomized traffic: ready, redirects, rare resets
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0, 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
